// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game obstacle logic.
package dino_pkg;

    localparam int X_W     = 10;
    localparam int N_CACTI = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CRASH = 2'd2
    } state_t;

    localparam logic [X_W:0] BASE_W = (X_W+1)'(8);

    // Cactus hitbox width in pixels: 8 + 4*type.
    function automatic logic [X_W:0] cactus_width(input logic [1:0] ctype);
        logic [X_W:0] w;
        w      = '0;
        w[3:2] = ctype;
        return w + BASE_W;
    endfunction

endpackage

// File: rtl/cactus_slot.sv
// One obstacle slot: holds valid/x/type, applies the per-tick move/expire and spawn load,
// and flags overlap with the dino using the post-update position.
module cactus_slot
    import dino_pkg::*;
#(
    parameter int SPAWN_X = 640,
    parameter int SPEED   = 4,
    parameter int DINO_X  = 64,
    parameter int DINO_W  = 16
) (
    input  logic           clk,
    input  logic           sys_rst,
    input  logic           clear,
    input  logic           tick,
    input  logic           spawn,
    input  logic [1:0]     spawn_type,
    input  logic           dino_airborne,
    output logic           moved_valid,
    output logic           hit,
    output logic           valid,
    output logic [X_W-1:0] x,
    output logic [1:0]     ctype
);

    localparam logic [X_W-1:0] SPEED_X   = X_W'(SPEED);
    localparam logic [X_W-1:0] SPAWN_X_V = X_W'(SPAWN_X);
    localparam logic [X_W:0]   HIT_L     = (X_W+1)'(DINO_X);
    localparam logic [X_W:0]   HIT_R     = (X_W+1)'(DINO_X + DINO_W);

    logic [X_W-1:0] moved_x;
    logic [1:0]     moved_type;
    logic           next_valid;
    logic [X_W-1:0] next_x;
    logic [1:0]     next_type;

    // Move/expire kept apart from spawn so the parent's free-slot search has no loop.
    always_comb begin
        moved_valid = valid;
        moved_x     = x;
        moved_type  = ctype;
        if (tick && valid) begin
            if (x < SPEED_X) begin
                moved_valid = 1'b0;
                moved_x     = '0;
                moved_type  = 2'd0;
            end else begin
                moved_x = x - SPEED_X;
            end
        end
    end

    always_comb begin
        next_valid = moved_valid;
        next_x     = moved_x;
        next_type  = moved_type;
        if (spawn) begin
            next_valid = 1'b1;
            next_x     = SPAWN_X_V;
            next_type  = spawn_type;
        end
        hit = tick && next_valid && !dino_airborne
              && ({1'b0, next_x} < HIT_R)
              && (({1'b0, next_x} + cactus_width(next_type)) > HIT_L);
    end

    always_ff @(posedge clk) begin
        if (sys_rst || clear) begin
            valid <= 1'b0;
            x     <= '0;
            ctype <= 2'd0;
        end else if (tick) begin
            valid <= next_valid;
            x     <= next_x;
            ctype <= next_type;
        end
    end

endmodule

// File: rtl/cactus_spawner.sv
// Obstacle scheduler: game FSM, spawn gap timer, free-slot priority encoder and score,
// driving one cactus_slot per on-screen obstacle.
module cactus_spawner
    import dino_pkg::*;
#(
    parameter int SPAWN_X  = 640,
    parameter int SPEED    = 4,
    parameter int INIT_GAP = 30,
    parameter int MIN_GAP  = 20,
    parameter int GAP_STEP = 4,
    parameter int DINO_X   = 64,
    parameter int DINO_W   = 16
) (
    input  logic                     clk,
    input  logic                     sys_rst,
    input  logic                     frame_tick,
    input  logic                     game_start,
    input  logic                     dino_airborne,
    input  logic [4:0]               rng_val,
    output logic                     rng_step,
    output logic [N_CACTI-1:0]       cactus_valid,
    output logic [N_CACTI*X_W-1:0]   cactus_x,
    output logic [2*N_CACTI-1:0]     cactus_type,
    output logic                     running,
    output logic                     crashed,
    output logic [15:0]              score
);

    localparam int GAP_W = 8;
    localparam logic [GAP_W-1:0] INIT_GAP_G = GAP_W'(INIT_GAP);
    localparam logic [GAP_W-1:0] MIN_GAP_G  = GAP_W'(MIN_GAP);
    localparam logic [GAP_W-1:0] GAP_STEP_G = GAP_W'(GAP_STEP);

    state_t             state;
    logic [GAP_W-1:0]   gap;
    logic [GAP_W-1:0]   gap_reload;
    logic               tick_go;
    logic               spawn_due;
    logic               spawn_now;
    logic               free_found;
    logic [N_CACTI-1:0] moved_valid;
    logic [N_CACTI-1:0] hit;
    logic [N_CACTI-1:0] spawn_sel;

    // A start pulse swallows a coincident frame tick.
    assign tick_go    = frame_tick && !game_start && (state == RUN);
    assign spawn_due  = tick_go && (gap == '0);
    assign gap_reload = MIN_GAP_G + GAP_W'(rng_val[4:2]) * GAP_STEP_G;
    assign spawn_now  = spawn_due && free_found;

    always_comb begin
        spawn_sel  = '0;
        free_found = 1'b0;
        for (int i = 0; i < N_CACTI; i++) begin
            if (!moved_valid[i] && !free_found) begin
                spawn_sel[i] = spawn_due;
                free_found   = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_CACTI; i++) begin : g_slot
        logic [X_W-1:0] slot_x;
        logic [1:0]     slot_type;

        cactus_slot #(
            .SPAWN_X (SPAWN_X),
            .SPEED   (SPEED),
            .DINO_X  (DINO_X),
            .DINO_W  (DINO_W)
        ) u_slot (
            .clk           (clk),
            .sys_rst       (sys_rst),
            .clear         (game_start),
            .tick          (tick_go),
            .spawn         (spawn_sel[i]),
            .spawn_type    (rng_val[1:0]),
            .dino_airborne (dino_airborne),
            .moved_valid   (moved_valid[i]),
            .hit           (hit[i]),
            .valid         (cactus_valid[i]),
            .x             (slot_x),
            .ctype         (slot_type)
        );

        assign cactus_x[i*X_W +: X_W]  = slot_x;
        assign cactus_type[2*i +: 2]   = slot_type;
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            gap      <= INIT_GAP_G;
            score    <= '0;
            rng_step <= 1'b0;
            running  <= 1'b0;
            crashed  <= 1'b0;
        end else begin
            rng_step <= spawn_now;
            if (game_start) begin
                state   <= RUN;
                running <= 1'b1;
                crashed <= 1'b0;
                gap     <= INIT_GAP_G;
                score   <= '0;
            end else if (tick_go) begin
                // With no free slot the gap stays at zero so the spawn retries next tick.
                if (gap != '0)
                    gap <= gap - 1'b1;
                else if (spawn_now)
                    gap <= gap_reload;
                if (score != 16'hFFFF)
                    score <= score + 16'd1;
                if (|hit) begin
                    state   <= CRASH;
                    running <= 1'b0;
                    crashed <= 1'b1;
                end
            end
        end
    end

endmodule
